hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Companion to the operand forwarding logic in the 5-stage RISC-V pipeline. It handles the producer-side hazards that forwarding cannot resolve:
  - load-use dependencies;
  - multi-cycle data-memory waits;
  - taken-branch flushes.
- It drives the PC/IF_ID write enables, the ID/EX bubble, the IF/ID flush and the EX/MEM hold.
- It also keeps a saturating count of stall cycles for performance monitoring.

Parameters:
- LOAD_STALL_CYCLES, 1: number of bubble cycles inserted per load-use hazard. Legal range 1..7.
- CNT_W, 16: width of the stall_count performance counter.

Ports:
- clk, input, 1: pipeline clock.
- rst, input, 1: synchronous, active-high reset.
- id_rs1, input, 5: rs1 of the instruction in ID.
- id_rs2, input, 5: rs2 of the instruction in ID.
- id_uses_rs2, input, 1: 1 = the ID instruction reads rs2. This is 0 for I-type, load and immediate ops.
- id_ex_MemRead, input, 1: the instruction in EX is a load.
- id_ex_WriteReg, input, 5: destination register of the instruction in EX.
- ex_branch_taken, input, 1: branch/jump resolved taken in EX.
- dmem_req, input, 1: the MEM stage is accessing data memory this cycle.
- dmem_ready, input, 1: data memory completes the access this cycle.
- perf_clear, input, 1: clears stall_count.
- PCWrite, output, 1: PC update enable.
- IF_ID_Write, output, 1: IF/ID register write enable.
- id_ex_bubble, output, 1: zero the ID/EX control fields.
- if_id_flush, output, 1: clear the IF/ID instruction to a NOP.
- ex_mem_hold, output, 1: hold the IF/ID, ID/EX and EX/MEM registers. This freezes the pipeline.
- stall_count, output, CNT_W: number of cycles with PCWrite=0.
- state, output, 2: current FSM state, for debug. RUN=0, LOAD_STALL=1, MEM_WAIT=2.

Behaviour:

Reset:
- While rst=1 at the clock edge: state=RUN, the internal bubble counter is 0 and stall_count is 0.
- While rst is high, the outputs are forced to PCWrite=1, IF_ID_Write=1, id_ex_bubble=0, if_id_flush=0, ex_mem_hold=0.
- Reset in any state returns to RUN on the next edge and drops any stall in progress.

Definitions (combinational, evaluated every cycle):
- load_use = id_ex_MemRead && id_ex_WriteReg!=0 && (id_ex_WriteReg==id_rs1 || (id_uses_rs2 && id_ex_WriteReg==id_rs2)).
- mem_busy = dmem_req && !dmem_ready.

Output priority (the outputs are Mealy, combinational from state and inputs):
1. mem_busy, in any state: ex_mem_hold=1, PCWrite=0, IF_ID_Write=0, id_ex_bubble=0, if_id_flush=0.
2. Otherwise, ex_branch_taken while in RUN: if_id_flush=1, id_ex_bubble=1, PCWrite=1, IF_ID_Write=1. Branch wins over load_use.
3. Otherwise, load_use while in RUN, or any cycle in LOAD_STALL: PCWrite=0, IF_ID_Write=0, id_ex_bubble=1.
4. Otherwise: PCWrite=1, IF_ID_Write=1, all other outputs 0.

FSM transitions:
- RUN:
  - mem_busy → MEM_WAIT, return state=RUN.
  - else load_use and LOAD_STALL_CYCLES>1 → LOAD_STALL, with counter=LOAD_STALL_CYCLES-2.
  - else stay in RUN. A load_use with LOAD_STALL_CYCLES=1 is a single stall cycle that stays in RUN.
- LOAD_STALL:
  - id_ex inputs are ignored, because the bubble is already in EX.
  - mem_busy → MEM_WAIT, return state=LOAD_STALL, counter held.
  - else counter==0 → RUN.
  - else decrement the counter.
- MEM_WAIT:
  - Stay while mem_busy.
  - On the first cycle with !mem_busy, go to the return state.
  - That release cycle uses the output rules of the return state. A pending ex_branch_taken or load_use is therefore acted on in that same cycle.
  - The counter is frozen throughout MEM_WAIT.
- ex_branch_taken is ignored in LOAD_STALL and MEM_WAIT. The EX instruction is frozen or bubbled, so the branch is re-seen when the pipeline resumes.

stall_count:
- Increments by 1 on every edge where rst=0 and PCWrite=0.
- Saturates at 2^CNT_W-1.
- perf_clear has priority over increment: it sets the count to 0 on that edge.

Writes to x0 never cause a stall.

Test Plan:
1. `lw x5` in EX (id_ex_MemRead=1, WriteReg=5), ID `add` with rs1=5, LOAD_STALL_CYCLES=1 → exactly 1 cycle of PCWrite=0, IF_ID_Write=0, id_ex_bubble=1; state stays 0; stall_count goes 0→1.
2. Same load as scenario 1, with ID rs2=5, id_uses_rs2=0, rs1=3 → no stall. Then WriteReg=0 with rs1=0 → no stall.
3. LOAD_STALL_CYCLES=3 with a load-use hazard → 3 consecutive bubble cycles; state sequence 0,1,1,0; stall_count=3.
4. dmem_req=1 with dmem_ready low for 4 cycles in RUN → ex_mem_hold=1 for 4 cycles; state=2; release on the 5th cycle with all enables 1; stall_count=4.
5. ex_branch_taken=1 together with a load_use hazard in RUN → if_id_flush=1, id_ex_bubble=1, PCWrite=1; no transition to LOAD_STALL.
6. LOAD_STALL_CYCLES=3: enter LOAD_STALL, then a 2-cycle mem_busy → state 1→2→2→1; the counter resumes from its held value; 5 total PCWrite=0 cycles. Then assert rst mid-LOAD_STALL → next edge state=0, stall_count=0, outputs at reset values.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Producer-side hazard control: load-use bubbles, data-memory wait freezes and
// taken-branch flushes, plus a saturating stall-cycle performance counter.
module hazard_stall_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_WriteReg,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // LOAD_STALL counts down to zero, so it is loaded with two less than the
  // total bubble count: the RUN detection cycle is already the first bubble.
  localparam int unsigned LS_INIT_I = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
  localparam logic [2:0]  LS_INIT   = 3'(LS_INIT_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff_state;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use;
  logic             mem_busy;

  always_comb begin
    load_use = id_ex_MemRead && (id_ex_WriteReg != 5'd0) &&
               ((id_ex_WriteReg == id_rs1) ||
                (id_uses_rs2 && (id_ex_WriteReg == id_rs2)));
    mem_busy = dmem_req && !dmem_ready;

    // The release cycle out of MEM_WAIT behaves exactly like the return state.
    eff_state = state_q;
    if (state_q == MEM_WAIT && !mem_busy) eff_state = ret_q;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;

    if (mem_busy) begin
      ex_mem_hold = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      if (state_q != MEM_WAIT) begin
        state_d = MEM_WAIT;
        ret_d   = state_q;
      end
    end else begin
      state_d = eff_state;
      case (eff_state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LS_INIT;
            end
          end
        end
        LOAD_STALL: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: state_d = RUN;
      endcase
    end

    if (rst) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      ex_mem_hold  = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (perf_clear)                               stall_count_d = '0;
    else if (!PCWrite && stall_count_q != CNT_MAX) stall_count_d = stall_count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ret_q         <= RUN;
      cnt_q         <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed plus randomized bench for hazard_stall_unit; two instances
// (1-cycle and 3-cycle load stalls) are checked against an owed-bubble model.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic       mr;
    logic [4:0] wr;
    logic       br;
    logic       req;
    logic       rdy;
    logic       pc;
  } in_t;

  logic       clk = 1'b0;
  logic       rst, id_uses_rs2, id_ex_MemRead, ex_branch_taken;
  logic       dmem_req, dmem_ready, perf_clear;
  logic [4:0] id_rs1, id_rs2, id_ex_WriteReg;

  logic [1:0]  pcw, ifw, bub, fl, hold;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic [1:0]  state_a, state_b;

  int errors = 0;
  int checks = 0;

  // Reference model: bubbles still owed after the current one, and whether
  // the pipeline is frozen on a memory wait.
  int owed[2];
  bit waiting[2];
  int cnt_m[2];
  int lsc[2]     = '{1, 3};
  int cnt_max[2] = '{65535, 7};

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_WriteReg(id_ex_WriteReg),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .perf_clear(perf_clear), .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]),
    .id_ex_bubble(bub[0]), .if_id_flush(fl[0]), .ex_mem_hold(hold[0]),
    .stall_count(cnt_a), .state(state_a)
  );

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_WriteReg(id_ex_WriteReg),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .perf_clear(perf_clear), .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]),
    .id_ex_bubble(bub[1]), .if_id_flush(fl[1]), .ex_mem_hold(hold[1]),
    .stall_count(cnt_b), .state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic in_t nop();
    in_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle, compare against the model before the edge, then advance the model.
  task automatic step(input in_t s, input string name);
    bit lu, busy;
    bit e_pcw, e_ifw, e_bub, e_fl, e_hold;
    int e_state;
    logic [31:0] o_cnt, o_state;
    @(negedge clk);
    rst             = s.rst;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_uses_rs2     = s.u2;
    id_ex_MemRead   = s.mr;
    id_ex_WriteReg  = s.wr;
    ex_branch_taken = s.br;
    dmem_req        = s.req;
    dmem_ready      = s.rdy;
    perf_clear      = s.pc;
    #1;
    lu   = s.mr && s.wr != 0 && (s.wr == s.rs1 || (s.u2 && s.wr == s.rs2));
    busy = s.req && !s.rdy;
    for (int k = 0; k < 2; k++) begin
      e_pcw = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_hold = 0;
      if (s.rst) begin
        // reset values already set
      end else if (busy) begin
        e_hold = 1; e_pcw = 0; e_ifw = 0;
      end else if (owed[k] > 0) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1;
      end else if (s.br) begin
        e_fl = 1; e_bub = 1;
      end else if (lu) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1;
      end
      e_state = waiting[k] ? 2 : (owed[k] > 0 ? 1 : 0);
      o_cnt   = (k == 0) ? 32'(cnt_a) : 32'(cnt_b);
      o_state = (k == 0) ? 32'(state_a) : 32'(state_b);
      check($sformatf("%s[%0d].PCWrite", name, k), 32'(pcw[k]), 32'(e_pcw));
      check($sformatf("%s[%0d].IF_ID_Write", name, k), 32'(ifw[k]), 32'(e_ifw));
      check($sformatf("%s[%0d].id_ex_bubble", name, k), 32'(bub[k]), 32'(e_bub));
      check($sformatf("%s[%0d].if_id_flush", name, k), 32'(fl[k]), 32'(e_fl));
      check($sformatf("%s[%0d].ex_mem_hold", name, k), 32'(hold[k]), 32'(e_hold));
      check($sformatf("%s[%0d].state", name, k), o_state, 32'(e_state));
      check($sformatf("%s[%0d].stall_count", name, k), o_cnt, 32'(cnt_m[k]));
      if (s.rst) begin
        owed[k] = 0; waiting[k] = 0; cnt_m[k] = 0;
      end else begin
        if (s.pc) cnt_m[k] = 0;
        else if (!e_pcw && cnt_m[k] < cnt_max[k]) cnt_m[k]++;
        if (busy) waiting[k] = 1;
        else begin
          waiting[k] = 0;
          if (owed[k] > 0) owed[k]--;
          else if (!s.br && lu) owed[k] = lsc[k] - 1;
        end
      end
    end
  endtask

  initial begin
    in_t s, rs, ld;
    rs = nop(); rs.rst = 1'b1;
    ld = nop(); ld.mr = 1'b1; ld.wr = 5'd5; ld.rs1 = 5'd5;
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; waiting[k] = 0; cnt_m[k] = 0;
    end
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0; id_ex_MemRead = 0;
    id_ex_WriteReg = '0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0; perf_clear = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a single load-use bubble.
    step(rs, "reset");
    step(ld, "s1_lu");
    step(nop(), "s1_after");
    check("s1_count_a", 32'(cnt_a), 32'd1);
    check("s1_state_a", 32'(state_a), 32'd0);

    // rs2 not read, and x0 destination: no stall.
    step(rs, "s2_rst");
    s = nop(); s.mr = 1; s.wr = 5'd5; s.rs1 = 5'd3; s.rs2 = 5'd5; s.u2 = 0;
    step(s, "s2_rs2_unused");
    s = nop(); s.mr = 1; s.wr = 5'd0; s.rs1 = 5'd0;
    step(s, "s2_x0");
    check("s2_pcwrite_a", 32'(pcw[0]), 32'd1);
    check("s2_count_a", 32'(cnt_a), 32'd0);

    // Three-cycle load stall.
    step(rs, "s3_rst");
    step(ld, "s3_lu");
    step(nop(), "s3_c1");
    step(nop(), "s3_c2");
    step(nop(), "s3_c3");
    check("s3_count_b", 32'(cnt_b), 32'd3);
    check("s3_state_b", 32'(state_b), 32'd0);

    // Four-cycle memory wait then release.
    step(rs, "s4_rst");
    s = nop(); s.req = 1; s.rdy = 0;
    for (int i = 0; i < 4; i++) step(s, "s4_busy");
    s.rdy = 1;
    step(s, "s4_release");
    check("s4_count_a", 32'(cnt_a), 32'd4);
    check("s4_hold_a", 32'(hold[0]), 32'd0);

    // Branch beats load-use.
    step(rs, "s5_rst");
    s = ld; s.br = 1;
    step(s, "s5_branch_lu");
    check("s5_flush_b", 32'(fl[1]), 32'd1);
    step(nop(), "s5_after");
    check("s5_state_b", 32'(state_b), 32'd0);

    // Load stall interrupted by a memory wait, then reset mid-stall.
    step(rs, "s6_rst");
    step(ld, "s6_lu");
    s = nop(); s.req = 1;
    step(s, "s6_busy1");
    step(s, "s6_busy2");
    check("s6_state_wait_b", 32'(state_b), 32'd2);
    step(nop(), "s6_release");
    step(nop(), "s6_ls");
    check("s6_state_ls_b", 32'(state_b), 32'd1);
    step(nop(), "s6_done");
    check("s6_count_b", 32'(cnt_b), 32'd5);
    step(ld, "s6b_lu");
    step(nop(), "s6b_ls");
    step(rs, "s6b_reset");
    step(nop(), "s6b_after");
    check("s6b_state_b", 32'(state_b), 32'd0);
    check("s6b_count_b", 32'(cnt_b), 32'd0);

    // Randomized traffic with a small register pool to force collisions.
    for (int i = 0; i < 800; i++) begin
      s.rst = ($urandom_range(0, 59) == 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.u2  = 1'($urandom_range(0, 1));
      s.mr  = 1'($urandom_range(0, 1));
      s.wr  = 5'($urandom_range(0, 3));
      s.br  = ($urandom_range(0, 5) == 0);
      s.req = ($urandom_range(0, 2) == 0);
      s.rdy = 1'($urandom_range(0, 1));
      s.pc  = ($urandom_range(0, 39) == 0);
      step(s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
